// File: rtl/matmul_mem_bridge.sv
// ---------------------------------------------------------------------------
// matmul_mem_bridge
//
// Memory port for the matrix-multiply engine. It turns the engine's
// request/acknowledge protocol (mem_operation code + addr_i + wdata_i, answered
// by a one-cycle mem_opdone) into a single access to a fixed-latency,
// single-port synchronous SRAM.
//
// Handshake: the engine presents a request code on mem_operation (01 = read,
// 11 = write, 00 = idle, 10 = reserved and ignored). The bridge samples it only
// in IDLE. Once it accepts a request, it ignores the engine inputs until it
// pulses mem_opdone for exactly one cycle in ACK. The engine may present its
// next request on the edge where it sees mem_opdone. That request is sampled in
// the IDLE cycle that follows, so each request is issued only once.
//
// FSM: IDLE -> ISSUE -> (write) ACK -> IDLE
//                    -> (read)  WAIT (RD_LAT cycles) -> ACK -> IDLE
//      IDLE -> ACK directly for an out-of-range address. In that case the
//      SRAM is not accessed and err_o is set.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   mem_operation[1:0]   request code from the engine
//   addr_i[31:0]         word address from the engine
//   wdata_i[DATA_W-1:0]  write data from the engine
//   rdata_o              registered read data; held until the next read
//   mem_opdone           one-cycle completion pulse
//   sram_csb/sram_web    SRAM chip select / write enable (active-low, registered)
//   sram_addr/sram_wdata SRAM address / write data (registered)
//   sram_rdata           SRAM read data
//   err_o                sticky out-of-range flag
//   busy_o               high whenever the FSM is not in IDLE
//   rd_count_o/wr_count_o  saturating success counters. These exist only when
//                          MATMUL_MEM_STATS_EN is defined.
//
// Optional feature macro: MATMUL_MEM_STATS_EN
// ---------------------------------------------------------------------------
module matmul_mem_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_operation,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_opdone,
  output logic              sram_csb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              err_o,
  output logic              busy_o
`ifdef MATMUL_MEM_STATS_EN
  ,
  output logic [15:0]       rd_count_o,
  output logic [15:0]       wr_count_o
`endif
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  logic             is_wr;     // latched op: 1 = write, 0 = read

`ifdef MATMUL_MEM_STATS_EN
  logic             ack_ok;    // the transaction now in ACK reached the SRAM
`endif

  logic valid_req;
  logic in_range;

  assign valid_req = (mem_operation == 2'b01) || (mem_operation == 2'b11);
  // The range check uses the full 32-bit address. Only the low ADDR_W bits
  // go to the SRAM.
  assign in_range  = (addr_i < 32'(DEPTH));
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      is_wr      <= 1'b0;
      mem_opdone <= 1'b0;
      rdata_o    <= '0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      err_o      <= 1'b0;
`ifdef MATMUL_MEM_STATS_EN
      ack_ok     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mem_opdone <= 1'b0;
          if (valid_req) begin
            is_wr <= mem_operation[1];
            if (in_range) begin
              // Set up the SRAM strobes now, so they are valid for the whole
              // ISSUE cycle.
              state      <= ISSUE;
              sram_csb   <= 1'b0;
              sram_web   <= ~mem_operation[1];
              sram_addr  <= addr_i[ADDR_W-1:0];
              sram_wdata <= wdata_i;
`ifdef MATMUL_MEM_STATS_EN
              ack_ok     <= 1'b1;
`endif
            end else begin
              state      <= ACK;
              mem_opdone <= 1'b1;
              err_o      <= 1'b1;
              if (!mem_operation[1]) begin
                rdata_o <= '0;
              end
`ifdef MATMUL_MEM_STATS_EN
              ack_ok     <= 1'b0;
`endif
            end
          end
        end

        ISSUE: begin
          sram_csb <= 1'b1;
          sram_web <= 1'b1;
          if (is_wr) begin
            state      <= ACK;
            mem_opdone <= 1'b1;
          end else begin
            state   <= WAIT;
            lat_cnt <= LAT_LOAD;
          end
        end

        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rdata_o    <= sram_rdata;
            lat_cnt    <= '0;
            state      <= ACK;
            mem_opdone <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LAT_LAST;
          end
        end

        ACK: begin
          mem_opdone <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state      <= IDLE;
          mem_opdone <= 1'b0;
          sram_csb   <= 1'b1;
          sram_web   <= 1'b1;
        end
      endcase
    end
  end

`ifdef MATMUL_MEM_STATS_EN
  // The counters advance at the close of the ACK cycle of a transaction that
  // reached the SRAM. They saturate instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (state == ACK && ack_ok) begin
      if (is_wr) begin
        if (wr_count_o != 16'hFFFF) begin
          wr_count_o <= wr_count_o + 16'd1;
        end
      end else begin
        if (rd_count_o != 16'hFFFF) begin
          rd_count_o <= rd_count_o + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_matmul_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_matmul_mem_bridge
//
// Directed bench for matmul_mem_bridge. It uses two instances:
//   dut1: RD_LAT=1, backed by a behavioural 1024-word synchronous SRAM.
//   dut3: RD_LAT=3, read data held at a fixed pattern; used for reset tests.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_matmul_mem_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- dut1 (RD_LAT = 1) ----------------
  logic        reset1;
  logic [1:0]  mem_op1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic [31:0] rdata1;
  logic        opdone1;
  logic        s1_csb;
  logic        s1_web;
  logic [9:0]  s1_addr;
  logic [31:0] s1_wdata;
  logic [31:0] s1_rdata;
  logic        err1;
  logic        busy1;
`ifdef MATMUL_MEM_STATS_EN
  logic [15:0] rd_cnt1;
  logic [15:0] wr_cnt1;
`endif

  matmul_mem_bridge #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .RD_LAT(1)) dut1 (
    .clk           (clk),
    .reset         (reset1),
    .mem_operation (mem_op1),
    .addr_i        (addr1),
    .wdata_i       (wdata1),
    .rdata_o       (rdata1),
    .mem_opdone    (opdone1),
    .sram_csb      (s1_csb),
    .sram_web      (s1_web),
    .sram_addr     (s1_addr),
    .sram_wdata    (s1_wdata),
    .sram_rdata    (s1_rdata),
    .err_o         (err1),
    .busy_o        (busy1)
`ifdef MATMUL_MEM_STATS_EN
    ,
    .rd_count_o    (rd_cnt1),
    .wr_count_o    (wr_cnt1)
`endif
  );

  // Behavioural single-port SRAM with a read latency of one cycle.
  logic [31:0] sram_mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
    sram_mem[0] = 32'd2;
    sram_mem[1] = 32'd3;
    sram_mem[2] = 32'd4;
    sram_mem[3] = 32'd5;
    sram_mem[5] = 32'hDEADBEEF;
    s1_rdata    = 32'h0;
  end
  always @(posedge clk) begin
    if (!s1_csb) begin
      if (!s1_web) sram_mem[s1_addr] <= s1_wdata;
      else         s1_rdata <= sram_mem[s1_addr];
    end
  end

  // ---------------- dut3 (RD_LAT = 3) ----------------
  logic        reset3;
  logic [1:0]  mem_op3;
  logic [31:0] addr3;
  logic [31:0] wdata3;
  logic [31:0] rdata3;
  logic        opdone3;
  logic        s3_csb;
  logic        s3_web;
  logic [9:0]  s3_addr;
  logic [31:0] s3_wdata;
  logic [31:0] s3_rdata;
  logic        err3;
  logic        busy3;
`ifdef MATMUL_MEM_STATS_EN
  logic [15:0] rd_cnt3;
  logic [15:0] wr_cnt3;
`endif

  matmul_mem_bridge #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .RD_LAT(3)) dut3 (
    .clk           (clk),
    .reset         (reset3),
    .mem_operation (mem_op3),
    .addr_i        (addr3),
    .wdata_i       (wdata3),
    .rdata_o       (rdata3),
    .mem_opdone    (opdone3),
    .sram_csb      (s3_csb),
    .sram_web      (s3_web),
    .sram_addr     (s3_addr),
    .sram_wdata    (s3_wdata),
    .sram_rdata    (s3_rdata),
    .err_o         (err3),
    .busy_o        (busy3)
`ifdef MATMUL_MEM_STATS_EN
    ,
    .rd_count_o    (rd_cnt3),
    .wr_count_o    (wr_cnt3)
`endif
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request on dut1 in the current (IDLE) cycle. The request is
  // dropped to 00 after it is sampled. Cycles are counted from T. The task
  // records the mem_opdone cycle, the first ISSUE cycle and the number of
  // chip-select cycles. It ends one cycle after ACK, with dut1 back in IDLE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int issue_at,
                        output int issues, output logic web_at_issue);
    mem_op1 = op; addr1 = a; wdata1 = wd;
    lat = -1; issue_at = -1; issues = 0; web_at_issue = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) mem_op1 = 2'b00;
      if (!s1_csb) begin
        issues++;
        if (issue_at < 0) begin
          issue_at = c;
          web_at_issue = s1_web;
        end
      end
      if (opdone1) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    check({tag, "_opdone_one_cycle"}, {31'd0, opdone1}, 32'd0);
  endtask

  int   lat, issue_at, issues, n_done, pulses;
  logic web_i;
  logic [31:0] got [0:3];

  initial begin
    reset1 = 1'b1; mem_op1 = 2'b00; addr1 = '0; wdata1 = '0;
    reset3 = 1'b1; mem_op3 = 2'b00; addr3 = '0; wdata3 = '0;
    s3_rdata = 32'h3333_0003;
    repeat (2) @(posedge clk);
    #1;

    // ---- reset state ----
    check("rst_opdone", {31'd0, opdone1}, 32'd0);
    check("rst_rdata",  rdata1, 32'd0);
    check("rst_csb",    {31'd0, s1_csb}, 32'd1);
    check("rst_web",    {31'd0, s1_web}, 32'd1);
    check("rst_addr",   {22'd0, s1_addr}, 32'd0);
    check("rst_wdata",  s1_wdata, 32'd0);
    check("rst_err",    {31'd0, err1}, 32'd0);
    check("rst_busy",   {31'd0, busy1}, 32'd0);
    check("rst3_csb",   {31'd0, s3_csb}, 32'd1);
    reset1 = 1'b0;
    reset3 = 1'b0;
    @(posedge clk); #1;

    // ---- read addr 5, RD_LAT=1 ----
    run_op("rd5", 2'b01, 32'd5, 32'd0, lat, issue_at, issues, web_i);
    check("rd5_latency",  lat, 32'd3);
    check("rd5_issue_at", issue_at, 32'd1);
    check("rd5_issues",   issues, 32'd1);
    check("rd5_web",      {31'd0, web_i}, 32'd1);
    check("rd5_data",     rdata1, 32'hDEADBEEF);
    check("rd5_err",      {31'd0, err1}, 32'd0);

    // ---- write addr 7 ----
    run_op("wr7", 2'b11, 32'd7, 32'h0000_0042, lat, issue_at, issues, web_i);
    check("wr7_latency",  lat, 32'd2);
    check("wr7_issue_at", issue_at, 32'd1);
    check("wr7_web",      {31'd0, web_i}, 32'd0);
    check("wr7_sram",     sram_mem[7], 32'h0000_0042);
    check("wr7_rdata_held", rdata1, 32'hDEADBEEF);

    // ---- read back addr 7 ----
    run_op("rd7", 2'b01, 32'd7, 32'd0, lat, issue_at, issues, web_i);
    check("rd7_latency", lat, 32'd3);
    check("rd7_data",    rdata1, 32'h0000_0042);

    // ---- reserved code 10 is ignored ----
    mem_op1 = 2'b10; addr1 = 32'd3;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rsv_busy", {31'd0, busy1}, 32'd0);
      check("rsv_csb",  {31'd0, s1_csb}, 32'd1);
    end
    mem_op1 = 2'b00;
    @(posedge clk); #1;

    // ---- back-to-back reads of 0..3 ----
    mem_op1 = 2'b01; addr1 = 32'd0;
    n_done = 0; issues = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (!s1_csb) issues++;
      if (opdone1) begin
        if (n_done < 4) got[n_done] = rdata1;
        n_done++;
        if (n_done >= 4) mem_op1 = 2'b00;
        else addr1 = n_done;
      end
    end
    check("b2b_pulses", n_done, 32'd4);
    check("b2b_issues", issues, 32'd4);
    check("b2b_d0", got[0], 32'd2);
    check("b2b_d1", got[1], 32'd3);
    check("b2b_d2", got[2], 32'd4);
    check("b2b_d3", got[3], 32'd5);

    // ---- out-of-range read at DEPTH ----
    run_op("oor", 2'b01, 32'd1024, 32'd0, lat, issue_at, issues, web_i);
    check("oor_latency", lat, 32'd1);
    check("oor_issues",  issues, 32'd0);
    check("oor_rdata",   rdata1, 32'd0);
    check("oor_err",     {31'd0, err1}, 32'd1);

    // Upper address bits count for the range check, even though the low bits are 5.
    run_op("oor_hi", 2'b11, 32'h0001_0005, 32'h1234_5678, lat, issue_at, issues, web_i);
    check("oor_hi_latency", lat, 32'd1);
    check("oor_hi_issues",  issues, 32'd0);
    check("oor_hi_mem",     sram_mem[5], 32'hDEADBEEF);

    // err_o stays set across a successful access.
    run_op("rd5b", 2'b01, 32'd5, 32'd0, lat, issue_at, issues, web_i);
    check("sticky_err",  {31'd0, err1}, 32'd1);
    check("rd5b_data",   rdata1, 32'hDEADBEEF);

    // ---- fresh reset, then 3 writes, 2 reads, 1 out-of-range read ----
    reset1 = 1'b1;
    #1;
    check("rst2_err",   {31'd0, err1}, 32'd0);
    check("rst2_rdata", rdata1, 32'd0);
    @(posedge clk); #1;
    reset1 = 1'b0;
    @(posedge clk); #1;
    run_op("sw10", 2'b11, 32'd10, 32'hA000_000A, lat, issue_at, issues, web_i);
    run_op("sw11", 2'b11, 32'd11, 32'hB000_000B, lat, issue_at, issues, web_i);
    run_op("sw12", 2'b11, 32'd12, 32'hC000_000C, lat, issue_at, issues, web_i);
    run_op("sr10", 2'b01, 32'd10, 32'd0, lat, issue_at, issues, web_i);
    check("sr10_data", rdata1, 32'hA000_000A);
    run_op("sr12", 2'b01, 32'd12, 32'd0, lat, issue_at, issues, web_i);
    check("sr12_data", rdata1, 32'hC000_000C);
    run_op("soor", 2'b01, 32'd2000, 32'd0, lat, issue_at, issues, web_i);
    check("soor_err", {31'd0, err1}, 32'd1);
`ifdef MATMUL_MEM_STATS_EN
    check("stats_wr", {16'd0, wr_cnt1}, 32'd3);
    check("stats_rd", {16'd0, rd_cnt1}, 32'd2);
`endif

    // ---- dut3: reset during ISSUE drops the chip select at once ----
    mem_op3 = 2'b01; addr3 = 32'd9;
    @(posedge clk); #1;
    mem_op3 = 2'b00;
    check("r3i_csb_issue", {31'd0, s3_csb}, 32'd0);
    reset3 = 1'b1;
    #1;
    check("r3i_csb_reset", {31'd0, s3_csb}, 32'd1);
    check("r3i_busy",      {31'd0, busy3}, 32'd0);
    @(posedge clk); #1;
    reset3 = 1'b0;
    @(posedge clk); #1;

    // ---- dut3: reset during WAIT ----
    mem_op3 = 2'b01; addr3 = 32'd9;
    @(posedge clk); #1;              // T+1: ISSUE
    mem_op3 = 2'b00;
    @(posedge clk); #1;              // T+2: WAIT
    check("r3w_busy_wait", {31'd0, busy3}, 32'd1);
    reset3 = 1'b1;
    #1;
    check("r3w_csb",    {31'd0, s3_csb}, 32'd1);
    check("r3w_opdone", {31'd0, opdone3}, 32'd0);
    check("r3w_busy",   {31'd0, busy3}, 32'd0);
    @(posedge clk); #1;
    reset3 = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (opdone3) pulses++;
    end
    check("r3w_no_opdone", pulses, 32'd0);
    check("r3w_idle",      {31'd0, busy3}, 32'd0);

    // A fresh read after the reset completes with the RD_LAT=3 timing.
    mem_op3 = 2'b01; addr3 = 32'd9;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) mem_op3 = 2'b00;
      if (opdone3) begin
        lat = c;
        break;
      end
    end
    check("r3_latency", lat, 32'd5);
    check("r3_data",    rdata3, 32'h3333_0003);
    check("r3_err",     {31'd0, err3}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_mem_bridge.md
# matmul_mem_bridge

Downstream memory port for the matrix-multiply engine. It converts the engine's request/acknowledge protocol into a fixed-latency, single-port synchronous SRAM access. Requests use the `mem_operation` code, `addr`, write data and a single-cycle `mem_opdone`. The block sits between the engine and the operand/result SRAM that holds the parameter words, A, B and C.

## Interface
Parameters:
- DATA_W, default 32: data word width; equals the codebase `TYPE_BW`.
- ADDR_W, default 10: SRAM address width.
- DEPTH, default 1024: number of implemented words, DEPTH ≤ 2^ADDR_W.
- RD_LAT, default 1: SRAM read latency in cycles, ≥ 1.

Ports (clock and reset first):
- clk, in, 1: the single clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- mem_operation, in, 2: request code from the engine. 01 = read, 11 = write, 00 = none, 10 = reserved (ignored).
- addr_i, in, 32: word address from the engine.
- wdata_i, in, DATA_W: write data from the engine.
- rdata_o, out, DATA_W: read data to the engine. Registered.
- mem_opdone, out, 1: one-cycle completion pulse.
- sram_csb, out, 1: SRAM chip select, active-low.
- sram_web, out, 1: SRAM write enable, active-low.
- sram_addr, out, ADDR_W: SRAM address.
- sram_wdata, out, DATA_W: SRAM write data.
- sram_rdata, in, DATA_W: SRAM read data.
- err_o, out, 1: sticky flag, set by any out-of-range access.
- busy_o, out, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Samples `mem_operation` every cycle.
  - 01 or 11 with addr_i < DEPTH: latch the address, op and wdata, then go to ISSUE.
  - 01 or 11 with addr_i ≥ DEPTH: set err_o and go to ACK directly, with no SRAM access. For a read, rdata_o ← 0.
  - 00 or 10: stay in IDLE.
- ISSUE, one cycle:
  - sram_csb = 0, sram_addr = addr_i[ADDR_W-1:0].
  - Write: sram_web = 0, sram_wdata = latched data; next state is ACK.
  - Read: sram_web = 1; next state is WAIT with the latency counter loaded to RD_LAT.
- WAIT:
  - The counter decrements each cycle.
  - When it reaches 1, rdata_o ← sram_rdata at the end of that cycle, and the next state is ACK.
- ACK: mem_opdone = 1 for exactly one cycle, then IDLE.
- Once accepted, inputs are ignored. A request that drops to 00 mid-transaction still completes and still pulses mem_opdone.
- rdata_o holds its value until the next read completes. Writes do not change rdata_o.
- Back-to-back requests: the engine updates mem_operation/addr_i on the edge where it sees mem_opdone. IDLE in the next cycle therefore samples the new request. No request is double-issued.
- Address width: the SRAM index is addr_i[ADDR_W-1:0]. The range check uses the full 32 bits against DEPTH.

## Timing
- Reset values, applied immediately and asynchronously:
  - State IDLE; mem_opdone = 0; rdata_o = 0.
  - sram_csb = 1; sram_web = 1; sram_addr = 0; sram_wdata = 0.
  - err_o = 0; busy_o = 0; latency counter = 0.
- Reset mid-transaction aborts with no mem_opdone. sram_csb deasserts immediately.
- Latencies, with the request sampled in IDLE at cycle T:
  - Read: ISSUE at T+1, data captured at end of T+1+RD_LAT, mem_opdone at T+2+RD_LAT.
  - Write: ISSUE (SRAM write) at T+1, mem_opdone at T+2.
  - Out-of-range access: mem_opdone at T+1.
- Minimum spacing between accepted requests is one IDLE cycle after ACK.
- All SRAM-side outputs are registered. In every state other than ISSUE, sram_csb = 1 and sram_web = 1.

## Configuration
- Macro `MATMUL_MEM_STATS_EN`.
- Defined: adds output ports rd_count_o [15:0] and wr_count_o [15:0].
  - Each increments in the ACK cycle of a successful read or write respectively.
  - Out-of-range accesses are not counted.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Read, RD_LAT=1: SRAM word 5 = 32'hDEADBEEF; pulse mem_operation=01 with addr_i=5 at T. Required: sram_csb=0 at T+1, mem_opdone at T+3, rdata_o=32'hDEADBEEF.
- Write then read: write 11 to addr 7 with wdata 32'h0000_0042. Required: mem_opdone at T+2. A following read of addr 7 returns 32'h42.
- Back-to-back reads: hold mem_operation=01 and step addr_i 0→1→2→3 on each mem_opdone, with words 2, 3, 4, 5 stored. Required: exactly four pulses, returning 2, 3, 4, 5 in order, with no duplicate ISSUE.
- Out of range: read addr 1024 with DEPTH=1024. Required: mem_opdone at T+1, rdata_o=0, err_o=1 and sticky; no sram_csb assertion.
- Reset in WAIT: assert reset during WAIT with RD_LAT=3. Required: sram_csb=1 and mem_opdone=0 immediately. After release the state is IDLE, and a new read completes normally.
- With `MATMUL_MEM_STATS_EN`: three writes, two reads and one out-of-range read. Required: wr_count_o=3, rd_count_o=2.
